// File: rtl/arb8_sched_ody_1201462.sv
// arb8_sched_ody_1201462
//
// Round-robin scheduler for one shared 8-to-1 word multiplexer. It picks one
// of eight requesters, drives the mux select and a one-hot grant, and forwards
// the granted requester's words to one downstream consumer. It counts the beats
// accepted in each grant and rotates the grant on a final beat, on the beat
// limit, or when the granted requester drops its request.
//
// Ports
//   clk        in   1      rising-edge clock
//   rst_n      in   1      asynchronous active-low reset
//   req        in   8      request, bit i = requester i
//   data_in    in   8*W    requester words, requester i at [i*W +: W]
//   last       in   8      final-beat flag, only the granted bit is used
//   out_ready  in   1      downstream accepts the current beat
//   out_valid  out  1      beat present on out_data
//   out_data   out  W      selected word, zero when out_valid is low
//   sel        out  3      registered mux select (granted index)
//   gnt        out  8      registered one-hot grant, zero when idle
//   beat_cnt   out  4      beats accepted in the current grant
module arb8_sched_ody_1201462 #(
  parameter int W         = 4,
  parameter int MAX_BEATS = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [7:0]     req,
  input  logic [8*W-1:0] data_in,
  input  logic [7:0]     last,
  input  logic           out_ready,
  output logic           out_valid,
  output logic [W-1:0]   out_data,
  output logic [2:0]     sel,
  output logic [7:0]     gnt,
  output logic [3:0]     beat_cnt
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_XFER = 1'b1
  } state_t;

  localparam logic [3:0] LIMIT_CNT = 4'(MAX_BEATS - 1);

  state_t     state_q, state_d;
  logic [2:0] sel_q, sel_d;
  logic [7:0] gnt_q, gnt_d;
  logic [3:0] beat_cnt_q, beat_cnt_d;
  logic [2:0] ptr_q, ptr_d;

  logic [W-1:0] words [8];
  logic         pick_found;
  logic [2:0]   pick_idx;
  logic         sel_req;
  logic         accept;
  logic         grant_end;

  // Search upward from the pointer, wrapping 7 -> 0; the 3-bit index wraps
  // by itself.
  function automatic logic [3:0] rr_pick(input logic [7:0] r, input logic [2:0] p);
    logic [2:0] idx;
    logic       found;
    logic [2:0] chosen;
    found  = 1'b0;
    chosen = p;
    for (int k = 0; k < 8; k++) begin
      idx = p + 3'(k);
      if (!found && r[idx]) begin
        found  = 1'b1;
        chosen = idx;
      end
    end
    return {found, chosen};
  endfunction

  for (genvar i = 0; i < 8; i++) begin : g_words
    assign words[i] = data_in[i*W +: W];
  end

  assign {pick_found, pick_idx} = rr_pick(req, ptr_q);

  // Output side is combinational from the registered select and state.
  assign sel_req   = req[sel_q];
  assign out_valid = (state_q == ST_XFER) && sel_req;
  assign out_data  = out_valid ? words[sel_q] : '0;

  assign accept    = out_valid && out_ready;
  // last and the beat limit together still make only one grant end.
  assign grant_end = accept && (last[sel_q] || (beat_cnt_q == LIMIT_CNT));

  always_comb begin
    state_d    = state_q;
    sel_d      = sel_q;
    gnt_d      = gnt_q;
    beat_cnt_d = beat_cnt_q;
    ptr_d      = ptr_q;
    unique case (state_q)
      ST_IDLE: begin
        if (pick_found) begin
          state_d    = ST_XFER;
          sel_d      = pick_idx;
          gnt_d      = 8'h01 << pick_idx;
          beat_cnt_d = '0;
        end
      end
      ST_XFER: begin
        if (!sel_req) begin
          // Requester went away: give up the grant without counting a beat.
          state_d = ST_IDLE;
          gnt_d   = '0;
          ptr_d   = sel_q + 3'd1;
        end else if (accept) begin
          beat_cnt_d = beat_cnt_q + 4'd1;
          if (grant_end) begin
            state_d = ST_IDLE;
            gnt_d   = '0;
            ptr_d   = sel_q + 3'd1;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      sel_q      <= '0;
      gnt_q      <= '0;
      beat_cnt_q <= '0;
      ptr_q      <= '0;
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      gnt_q      <= gnt_d;
      beat_cnt_q <= beat_cnt_d;
      ptr_q      <= ptr_d;
    end
  end

  assign sel      = sel_q;
  assign gnt      = gnt_q;
  assign beat_cnt = beat_cnt_q;

endmodule

// File: tb/tb_arb8_sched_ody_1201462.sv
module tb_arb8_sched_ody_1201462;

  localparam int W = 4;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [7:0]     req;
  logic [8*W-1:0] data_in;
  logic [7:0]     last;
  logic           out_ready;
  logic           out_valid;
  logic [W-1:0]   out_data;
  logic [2:0]     sel;
  logic [7:0]     gnt;
  logic [3:0]     beat_cnt;

  int errors = 0;
  int checks = 0;

  arb8_sched_ody_1201462 #(.W(W), .MAX_BEATS(4)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .data_in(data_in), .last(last),
    .out_ready(out_ready), .out_valid(out_valid), .out_data(out_data),
    .sel(sel), .gnt(gnt), .beat_cnt(beat_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_word(input int i, input logic [W-1:0] v);
    data_in[i*W +: W] = v;
  endtask

  // Asynchronous reset pulse away from the clock edge, inputs idle.
  task automatic do_reset();
    req = 8'h00; last = 8'h00; out_ready = 1'b0;
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req = 8'($urandom); data_in = 32'($urandom); last = 8'($urandom); out_ready = 1'($urandom);
    #3;
    checks++; if (gnt !== 8'h00) begin errors++; $display("FAIL reset_gnt: got %h want 00", gnt); end
    checks++; if (sel !== 3'd0) begin errors++; $display("FAIL reset_sel: got %0d want 0", sel); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", out_valid); end
    checks++; if (out_data !== 4'h0) begin errors++; $display("FAIL reset_data: got %h want 0", out_data); end
    checks++; if (beat_cnt !== 4'd0) begin errors++; $display("FAIL reset_beat: got %0d want 0", beat_cnt); end
    // clocks while held in reset must change nothing
    tick(); tick();
    checks++; if (gnt !== 8'h00) begin errors++; $display("FAIL reset_hold_gnt: got %h want 00", gnt); end
    #2;
    req = 8'h08; last = 8'h00; out_ready = 1'b0;
    rst_n = 1'b1;
    tick();
    checks++; if (gnt !== 8'h08) begin errors++; $display("FAIL release_gnt: got %h want 08", gnt); end
    checks++; if (sel !== 3'd3) begin errors++; $display("FAIL release_sel: got %0d want 3", sel); end
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL release_valid: got %b want 1", out_valid); end
  endtask

  // Continues from the grant to requester 3 left by test_reset.
  task automatic test_single_last();
    logic [W-1:0] seq [3];
    seq[0] = 4'hA; seq[1] = 4'hB; seq[2] = 4'hC;
    out_ready = 1'b1;
    for (int b = 0; b < 3; b++) begin
      set_word(3, seq[b]);
      last = (b == 2) ? 8'h08 : 8'h00;
      #1;
      checks++; if (out_data !== seq[b]) begin errors++; $display("FAIL single_data%0d: got %h want %h", b, out_data, seq[b]); end
      checks++; if (beat_cnt !== 4'(b)) begin errors++; $display("FAIL single_beat%0d: got %0d want %0d", b, beat_cnt, b); end
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL single_valid%0d: got %b want 1", b, out_valid); end
      tick();
    end
    last = 8'h00;
    req  = 8'h18;
    #1;
    checks++; if (gnt !== 8'h00) begin errors++; $display("FAIL single_idle_gnt: got %h want 00", gnt); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL single_idle_valid: got %b want 0", out_valid); end
    checks++; if (sel !== 3'd3) begin errors++; $display("FAIL single_idle_sel: got %0d want 3", sel); end
    tick();
    // pointer at 4: requesters 3 and 4 both ask, 4 wins
    checks++; if (gnt !== 8'h10) begin errors++; $display("FAIL single_ptr_gnt: got %h want 10", gnt); end
    checks++; if (sel !== 3'd4) begin errors++; $display("FAIL single_ptr_sel: got %0d want 4", sel); end
  endtask

  task automatic test_full_contention();
    int e;
    do_reset();
    data_in = 32'h76543210;
    req = 8'hFF; last = 8'hFF; out_ready = 1'b1;
    for (int g = 0; g < 9; g++) begin
      e = g % 8;
      tick();
      checks++; if (gnt !== (8'h01 << e)) begin errors++; $display("FAIL rr_gnt%0d: got %h want %h", g, gnt, 8'h01 << e); end
      checks++; if (out_data !== 4'(e)) begin errors++; $display("FAIL rr_data%0d: got %h want %h", g, out_data, 4'(e)); end
      tick();
      checks++; if (out_valid !== 1'b0 || gnt !== 8'h00) begin errors++; $display("FAIL rr_gap%0d: got valid=%b gnt=%h want valid=0 gnt=00", g, out_valid, gnt); end
    end
  endtask

  task automatic test_beat_limit();
    do_reset();
    data_in = 32'h0;
    req = 8'h20; last = 8'h00; out_ready = 1'b1;
    tick();
    checks++; if (gnt !== 8'h20) begin errors++; $display("FAIL limit_gnt5: got %h want 20", gnt); end
    req = 8'h21;
    for (int b = 0; b < 4; b++) begin
      set_word(5, 4'(5 + b));
      #1;
      checks++; if (beat_cnt !== 4'(b) || gnt !== 8'h20) begin errors++; $display("FAIL limit_beat%0d: got cnt=%0d gnt=%h want cnt=%0d gnt=20", b, beat_cnt, gnt, b); end
      checks++; if (out_data !== 4'(5 + b)) begin errors++; $display("FAIL limit_data%0d: got %h want %h", b, out_data, 4'(5 + b)); end
      tick();
    end
    checks++; if (gnt !== 8'h00 || out_valid !== 1'b0) begin errors++; $display("FAIL limit_end: got gnt=%h valid=%b want gnt=00 valid=0", gnt, out_valid); end
    tick();
    checks++; if (gnt !== 8'h01) begin errors++; $display("FAIL limit_next: got %h want 01", gnt); end
  endtask

  task automatic test_backpressure_abandon();
    do_reset();
    data_in = 32'h0;
    set_word(2, 4'h9);
    req = 8'h04; last = 8'h00; out_ready = 1'b0;
    tick();
    checks++; if (gnt !== 8'h04 || sel !== 3'd2) begin errors++; $display("FAIL bp_grant: got gnt=%h sel=%0d want gnt=04 sel=2", gnt, sel); end
    for (int c = 0; c < 5; c++) begin
      checks++; if (out_data !== 4'h9 || beat_cnt !== 4'd0 || out_valid !== 1'b1) begin errors++; $display("FAIL bp_hold%0d: got data=%h cnt=%0d valid=%b want 9/0/1", c, out_data, beat_cnt, out_valid); end
      tick();
    end
    checks++; if (gnt !== 8'h04) begin errors++; $display("FAIL bp_gnt_hold: got %h want 04", gnt); end
    req = 8'h08; out_ready = 1'b1;
    #1;
    checks++; if (out_valid !== 1'b0 || out_data !== 4'h0) begin errors++; $display("FAIL abandon_valid: got valid=%b data=%h want 0/0", out_valid, out_data); end
    tick();
    checks++; if (gnt !== 8'h00 || beat_cnt !== 4'd0) begin errors++; $display("FAIL abandon_idle: got gnt=%h cnt=%0d want 00/0", gnt, beat_cnt); end
    req = 8'h0C;
    tick();
    // pointer at 3: requesters 2 and 3 both ask, 3 wins
    checks++; if (gnt !== 8'h08) begin errors++; $display("FAIL abandon_ptr: got %h want 08", gnt); end
  endtask

  task automatic test_reset_mid_grant();
    do_reset();
    data_in = 32'h0;
    set_word(6, 4'h7);
    req = 8'h40; last = 8'h00; out_ready = 1'b1;
    tick();
    tick();
    tick();
    checks++; if (beat_cnt !== 4'd2 || gnt !== 8'h40) begin errors++; $display("FAIL mid_pre: got cnt=%0d gnt=%h want 2/40", beat_cnt, gnt); end
    #1;
    rst_n = 1'b0;
    #1;
    checks++; if (gnt !== 8'h00 || sel !== 3'd0 || beat_cnt !== 4'd0) begin errors++; $display("FAIL mid_regs: got gnt=%h sel=%0d cnt=%0d want 00/0/0", gnt, sel, beat_cnt); end
    checks++; if (out_valid !== 1'b0 || out_data !== 4'h0) begin errors++; $display("FAIL mid_out: got valid=%b data=%h want 0/0", out_valid, out_data); end
    req = 8'h41;
    rst_n = 1'b1;
    tick();
    checks++; if (gnt !== 8'h01 || sel !== 3'd0) begin errors++; $display("FAIL mid_after: got gnt=%h sel=%0d want 01/0", gnt, sel); end
  endtask

  initial begin
    rst_n = 1'b0; req = 8'h00; data_in = '0; last = 8'h00; out_ready = 1'b0;
    test_reset();
    test_single_last();
    test_full_contention();
    test_beat_limit();
    test_backpressure_abandon();
    test_reset_mid_grant();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
